// File: rtl/imem_ctrl_pkg.sv
// Shared types and defaults for the instruction-RAM boot loader.
package imem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT       = 32'h0000_0013;
    localparam logic [31:0] INSTR_SEG_BEGIN_DEFAULT = 32'h0000_2000;
    localparam int          IMEM_WORDS_DEFAULT      = 2048;

endpackage

// File: rtl/byte_word_packer.sv
// Packs an LSB-first byte stream into 32-bit little-endian words.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    input  logic        clear_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] shifted;

    // Newest byte enters at the top so the first byte ends up in [7:0].
    assign shifted = {byte_i, shreg_q[31:8]};

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        if (clear_i) begin
            byte_cnt_d = 2'd0;
            shreg_d    = 32'd0;
        end else if (accept_i) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shreg_d    = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= 2'd0;
            shreg_q    <= 32'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

    // The completed word is visible in the same cycle as its last byte.
    assign word_done_o = accept_i & ~clear_i & (byte_cnt_q == 2'd3);
    assign word_o      = accept_i ? shifted : shreg_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte image into instruction RAM, then releases the core.
module imem_boot_loader
    import imem_ctrl_pkg::*;
#(
    parameter logic [31:0] INSTR_SEG_BEGIN = INSTR_SEG_BEGIN_DEFAULT,
    parameter int          IMEM_WORDS      = IMEM_WORDS_DEFAULT,
    parameter logic [31:0] NOP_INSTR       = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_byte_i,
    output logic        ld_ready_o,
    input  logic        reload_i,
    input  logic [31:0] fetch_pc_i,
    output logic [31:0] fetch_instr_o,
    output logic        core_run_o,
    output logic        load_err_o,
    output logic [31:0] addr_imem_ram_o,
    output logic [31:0] wr_instr_imem_ram_o,
    output logic        wr_en_imem_ram_o,
    input  logic [31:0] read_instr_imem_ram_i
);

    localparam int IDX_W = $clog2(IMEM_WORDS) + 1;

    state_e             state_q, state_d;
    logic [31:0]        len_q, len_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic               core_run_q, core_run_d;
    logic               load_err_q, load_err_d;

    logic               accept;
    logic [31:0]        word;
    logic               word_done;
    logic [31:0]        seg_addr;

    assign ld_ready_o = rst_n & ~reload_i & ((state_q == ST_HDR) | (state_q == ST_LOAD));
    assign accept     = ld_valid_i & ld_ready_o;

    byte_word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept_i    (accept),
        .byte_i      (ld_byte_i),
        .clear_i     (reload_i),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        load_err_d = load_err_q;
        case (state_q)
            ST_HDR: begin
                if (word_done) begin
                    len_d = word;
                    if (word == 32'd0)
                        state_d = ST_DONE;
                    else if (word > 32'(IMEM_WORDS))
                        state_d = ST_ERR;
                    else
                        state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_done)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                if (32'(word_idx_q) + 32'd1 == len_q)
                    state_d = ST_DONE;
                else
                    state_d = ST_LOAD;
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_HDR;
        endcase
        if (state_d == ST_ERR)
            load_err_d = 1'b1;
        // Reload overrides everything; a coinciding write still reaches the RAM port.
        if (reload_i) begin
            state_d    = ST_HDR;
            len_d      = 32'd0;
            word_idx_d = '0;
            load_err_d = 1'b0;
        end
        core_run_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HDR;
            len_q      <= 32'd0;
            word_idx_q <= '0;
            core_run_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            core_run_q <= core_run_d;
            load_err_q <= load_err_d;
        end
    end

    assign seg_addr = INSTR_SEG_BEGIN + (32'(word_idx_q) << 2);

    always_comb begin
        addr_imem_ram_o     = 32'd0;
        wr_instr_imem_ram_o = 32'd0;
        wr_en_imem_ram_o    = 1'b0;
        fetch_instr_o       = 32'd0;
        if (rst_n) begin
            if (state_q == ST_DONE) begin
                addr_imem_ram_o = fetch_pc_i;
                fetch_instr_o   = read_instr_imem_ram_i;
            end else begin
                addr_imem_ram_o = seg_addr;
                fetch_instr_o   = NOP_INSTR;
            end
            if (state_q == ST_WRITE) begin
                wr_en_imem_ram_o    = 1'b1;
                wr_instr_imem_ram_o = word;
            end
        end
    end

    assign core_run_o = core_run_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a small behavioural instruction RAM.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_ready_o;
    logic        reload_i;
    logic [31:0] fetch_pc_i;
    logic [31:0] fetch_instr_o;
    logic        core_run_o;
    logic        load_err_o;
    logic [31:0] addr_imem_ram_o;
    logic [31:0] wr_instr_imem_ram_o;
    logic        wr_en_imem_ram_o;
    logic [31:0] read_instr_imem_ram_i;

    int passed = 0;
    int total  = 0;
    int wr_cnt = 0;
    int wr_base;
    logic [31:0] ram [0:63];

    always #5 clk = ~clk;

    imem_boot_loader dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ld_valid_i            (ld_valid_i),
        .ld_byte_i             (ld_byte_i),
        .ld_ready_o            (ld_ready_o),
        .reload_i              (reload_i),
        .fetch_pc_i            (fetch_pc_i),
        .fetch_instr_o         (fetch_instr_o),
        .core_run_o            (core_run_o),
        .load_err_o            (load_err_o),
        .addr_imem_ram_o       (addr_imem_ram_o),
        .wr_instr_imem_ram_o   (wr_instr_imem_ram_o),
        .wr_en_imem_ram_o      (wr_en_imem_ram_o),
        .read_instr_imem_ram_i (read_instr_imem_ram_i)
    );

    assign read_instr_imem_ram_i = ram[addr_imem_ram_o[7:2]];

    always @(posedge clk) begin
        if (rst_n && wr_en_imem_ram_o) begin
            ram[addr_imem_ram_o[7:2]] <= wr_instr_imem_ram_o;
            wr_cnt <= wr_cnt + 1;
            $display("write  addr=%h data=%h", addr_imem_ram_o, wr_instr_imem_ram_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        #1;
        waited = 0;
        while (!ld_ready_o && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!ld_ready_o) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        ld_valid_i = 1'b0;
        $display("byte   %h", b);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload_i = 1'b1;
        @(negedge clk);
        reload_i = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'd0;
        rst_n      = 1'b0;
        ld_valid_i = 1'b0;
        ld_byte_i  = 8'd0;
        reload_i   = 1'b0;
        fetch_pc_i = 32'h0000_2004;

        // Reset: every output low
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", {31'd0, ld_ready_o}, 32'd0);
        check("rst_run",   {31'd0, core_run_o}, 32'd0);
        check("rst_addr",  addr_imem_ram_o, 32'd0);
        check("rst_fetch", fetch_instr_o, 32'd0);
        check("rst_wren",  {31'd0, wr_en_imem_ram_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("hdr_ready", {31'd0, ld_ready_o}, 32'd1);
        check("hdr_addr",  addr_imem_ram_o, 32'h0000_2000);
        check("hdr_nop",   fetch_instr_o, 32'h0000_0013);
        @(negedge clk);

        // Two-word image
        send_word(32'h0000_0002, 0);
        send_word(32'h0010_0513, 0);
        check("w0_en",   {31'd0, wr_en_imem_ram_o}, 32'd1);
        check("w0_addr", addr_imem_ram_o, 32'h0000_2000);
        check("w0_data", wr_instr_imem_ram_o, 32'h0010_0513);
        check("w0_nop",  fetch_instr_o, 32'h0000_0013);
        send_word(32'h0020_0593, 0);
        check("w1_en",   {31'd0, wr_en_imem_ram_o}, 32'd1);
        check("w1_addr", addr_imem_ram_o, 32'h0000_2004);
        check("w1_data", wr_instr_imem_ram_o, 32'h0020_0593);
        check("w1_run0", {31'd0, core_run_o}, 32'd0);
        @(negedge clk);
        #1;
        check("done_run",   {31'd0, core_run_o}, 32'd1);
        check("done_ready", {31'd0, ld_ready_o}, 32'd0);
        check("done_wren",  {31'd0, wr_en_imem_ram_o}, 32'd0);
        check("fetch_addr", addr_imem_ram_o, 32'h0000_2004);
        check("fetch_data", fetch_instr_o, 32'h0020_0593);
        check("wr_cnt2",    wr_cnt, 32'd2);

        // Zero-length header goes straight to DONE
        pulse_reload();
        check("rl_run0",  {31'd0, core_run_o}, 32'd0);
        check("rl_ready", {31'd0, ld_ready_o}, 32'd1);
        wr_base = wr_cnt;
        send_word(32'h0000_0000, 0);
        check("z_run",   {31'd0, core_run_o}, 32'd1);
        check("z_ready", {31'd0, ld_ready_o}, 32'd0);
        check("z_nowr",  wr_cnt - wr_base, 32'd0);

        // 2049 words exceeds capacity
        pulse_reload();
        send_word(32'h0000_0801, 0);
        check("e_err",   {31'd0, load_err_o}, 32'd1);
        check("e_ready", {31'd0, ld_ready_o}, 32'd0);
        check("e_run",   {31'd0, core_run_o}, 32'd0);
        pulse_reload();
        check("e_clr",   {31'd0, load_err_o}, 32'd0);
        check("e_hdr",   {31'd0, ld_ready_o}, 32'd1);

        // 2048 words is the largest accepted length
        send_word(32'h0000_0800, 0);
        check("max_noerr", {31'd0, load_err_o}, 32'd0);
        check("max_ready", {31'd0, ld_ready_o}, 32'd1);
        pulse_reload();

        // Three words with random gaps on ld_valid_i
        wr_base = wr_cnt;
        send_word(32'h0000_0003, 2);
        send_word(32'h1122_3344, 2);
        send_word(32'hDEAD_BEEF, 2);
        send_word(32'h0BAD_F00D, 2);
        @(negedge clk);
        #1;
        check("r_cnt",  wr_cnt - wr_base, 32'd3);
        check("r_ram0", ram[0], 32'h1122_3344);
        check("r_ram1", ram[1], 32'hDEAD_BEEF);
        check("r_ram2", ram[2], 32'h0BAD_F00D);
        check("r_run",  {31'd0, core_run_o}, 32'd1);

        // Reload after 5 of 8 data bytes; fifth byte must be discarded
        pulse_reload();
        send_word(32'h0000_0002, 0);
        send_word(32'hDDCC_BBAA, 0);
        send_byte(8'hEE);
        pulse_reload();
        send_word(32'h0000_0001, 0);
        send_word(32'h1234_5678, 0);
        check("p_addr", addr_imem_ram_o, 32'h0000_2000);
        check("p_data", wr_instr_imem_ram_o, 32'h1234_5678);
        @(negedge clk);
        #1;
        check("p_ram0", ram[0], 32'h1234_5678);
        check("p_ram1", ram[1], 32'hDEAD_BEEF);
        check("p_run",  {31'd0, core_run_o}, 32'd1);

        // Asynchronous reset in the middle of a load
        pulse_reload();
        send_word(32'h0000_0001, 0);
        send_byte(8'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ready", {31'd0, ld_ready_o}, 32'd0);
        check("ar_addr",  addr_imem_ram_o, 32'd0);
        check("ar_fetch", fetch_instr_o, 32'd0);
        check("ar_run",   {31'd0, core_run_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_hdr", {31'd0, ld_ready_o}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
